// File: rtl/rle_stream_scheduler_pkg.sv
// Shared constants for the RLE stream scheduler: channel tags, framing bytes,
// CRC-8 parameters, FSM encoding and the round-robin pick helper.
package rle_stream_scheduler_pkg;

    localparam logic [1:0] TAG_Y    = 2'b00;
    localparam logic [1:0] TAG_U    = 2'b01;
    localparam logic [1:0] TAG_V    = 2'b10;
    localparam logic [1:0] TAG_CTRL = 2'b11;

    localparam logic [7:0] MARKER_BYTE = {TAG_CTRL, 6'd0};
    localparam logic [7:0] CRC_POLY    = 8'h07;
    localparam logic [7:0] CRC_INIT    = 8'h00;

    typedef enum logic [2:0] {
        ST_ARB,
        ST_HDR,
        ST_VAL,
        ST_MARK,
        ST_ROWIDX,
        ST_CRC
    } sched_state_e;

    // First valid channel at or after ptr, scanning Y -> U -> V and wrapping.
    function automatic logic [1:0] rr_pick(input logic [2:0] valid, input logic [1:0] ptr);
        logic [2:0] idx;
        logic [1:0] pick;
        pick = ptr;
        for (int k = 2; k >= 0; k--) begin
            idx = 3'(ptr) + 3'(k);
            if (idx >= 3'd3) begin
                idx = idx - 3'd3;
            end
            if (valid[idx]) begin
                pick = idx[1:0];
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rle_stream_scheduler_crc8.sv
// Combinational CRC-8 byte step (poly 0x07, MSB-first), used by the
// scheduler only when RLE_SCHED_ROW_CRC_EN is defined.
module rle_crc8_byte
    import rle_stream_scheduler_pkg::*;
(
    input  logic [7:0] crc_i,
    input  logic [7:0] byte_i,
    output logic [7:0] crc_o
);

    always_comb begin
        crc_o = crc_i ^ byte_i;
        for (int b = 0; b < 8; b++) begin
            crc_o = crc_o[7] ? ((crc_o << 1) ^ CRC_POLY) : (crc_o << 1);
        end
    end

endmodule

// File: rtl/rle_stream_scheduler.sv
// Round-robin serializer of Y/U/V RLE tokens onto one UART byte lane, with
// per-row 0xC0 + row-index framing (plus CRC-8 byte under RLE_SCHED_ROW_CRC_EN).
module rle_stream_scheduler
    import rle_stream_scheduler_pkg::*;
#(
    parameter int CountWidth  = 6,
    parameter int RowIdxWidth = 8
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [2:0]              i_tok_valid,
    input  logic [23:0]             i_tok_val,
    input  logic [3*CountWidth-1:0] i_tok_count,
    output logic [2:0]              o_tok_ready,
    input  logic                    i_row_end,
    output logic [7:0]              o_frame,
    output logic                    o_valid,
    input  logic                    i_tx_ready,
    output logic                    o_row_done
);

    sched_state_e           state_q, state_d;
    logic [1:0]             ptr_q, ptr_d;
    logic [RowIdxWidth-1:0] row_idx_q, row_idx_d;
    logic                   row_pend_q, row_pend_d;
    logic                   row_done_q, row_done_d;
    logic [1:0]             tag_q, tag_d;
    logic [7:0]             val_q, val_d;
    logic [CountWidth-1:0]  cnt_q, cnt_d;
    logic [2:0]             tok_ready;
    logic [1:0]             grant;
    logic [CountWidth-1:0]  grant_cnt;

`ifdef RLE_SCHED_ROW_CRC_EN
    logic [7:0] crc_q, crc_d, crc_next;

    rle_crc8_byte u_crc (
        .crc_i  (crc_q),
        .byte_i (o_frame),
        .crc_o  (crc_next)
    );
`endif

    assign grant       = rr_pick(i_tok_valid, ptr_q);
    assign grant_cnt   = i_tok_count[CountWidth*int'(grant) +: CountWidth];
    assign o_tok_ready = tok_ready & {3{RST}};
    assign o_row_done  = row_done_q;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        row_idx_d  = row_idx_q;
        row_pend_d = row_pend_q | i_row_end;
        row_done_d = 1'b0;
        tag_d      = tag_q;
        val_d      = val_q;
        cnt_d      = cnt_q;
        tok_ready  = 3'b000;
        o_valid    = 1'b0;
        o_frame    = 8'h00;
`ifdef RLE_SCHED_ROW_CRC_EN
        crc_d      = crc_q;
`endif
        case (state_q)
            ST_ARB: begin
                // Tokens always win over the pending row marker.
                if (i_tx_ready) begin
                    if (|i_tok_valid) begin
                        tok_ready[grant] = 1'b1;
                        ptr_d = (grant == 2'd2) ? 2'd0 : grant + 2'd1;
                        tag_d = grant;
                        val_d = i_tok_val[8*int'(grant) +: 8];
                        cnt_d = grant_cnt;
                        if (grant_cnt != '0) begin
                            state_d = ST_HDR;
                        end
                    end else if (row_pend_q) begin
                        state_d = ST_MARK;
                    end
                end
            end
            ST_HDR: begin
                o_valid = 1'b1;
                o_frame = {tag_q, cnt_q};
                if (i_tx_ready) begin
                    state_d = ST_VAL;
`ifdef RLE_SCHED_ROW_CRC_EN
                    crc_d = crc_next;
`endif
                end
            end
            ST_VAL: begin
                o_valid = 1'b1;
                o_frame = val_q;
                if (i_tx_ready) begin
                    state_d = ST_ARB;
`ifdef RLE_SCHED_ROW_CRC_EN
                    crc_d = crc_next;
`endif
                end
            end
            ST_MARK: begin
                o_valid = 1'b1;
                o_frame = MARKER_BYTE;
                if (i_tx_ready) begin
                    state_d = ST_ROWIDX;
                end
            end
            ST_ROWIDX: begin
                o_valid = 1'b1;
                o_frame = 8'(row_idx_q);
                if (i_tx_ready) begin
`ifdef RLE_SCHED_ROW_CRC_EN
                    state_d = ST_CRC;
`else
                    state_d    = ST_ARB;
                    row_pend_d = 1'b0;
                    row_idx_d  = row_idx_q + {{(RowIdxWidth-1){1'b0}}, 1'b1};
                    row_done_d = 1'b1;
`endif
                end
            end
`ifdef RLE_SCHED_ROW_CRC_EN
            ST_CRC: begin
                o_valid = 1'b1;
                o_frame = crc_q;
                if (i_tx_ready) begin
                    state_d    = ST_ARB;
                    row_pend_d = 1'b0;
                    row_idx_d  = row_idx_q + {{(RowIdxWidth-1){1'b0}}, 1'b1};
                    row_done_d = 1'b1;
                    crc_d      = CRC_INIT;
                end
            end
`endif
            default: begin
                state_d = ST_ARB;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= ST_ARB;
            ptr_q      <= TAG_Y;
            row_idx_q  <= '0;
            row_pend_q <= 1'b0;
            row_done_q <= 1'b0;
`ifdef RLE_SCHED_ROW_CRC_EN
            crc_q      <= CRC_INIT;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            row_idx_q  <= row_idx_d;
            row_pend_q <= row_pend_d;
            row_done_q <= row_done_d;
`ifdef RLE_SCHED_ROW_CRC_EN
            crc_q      <= crc_d;
`endif
        end
    end

    // Token payload is only read in HDR/VAL, after a grant has loaded it.
    always_ff @(posedge CLK) begin
        tag_q <= tag_d;
        val_q <= val_d;
        cnt_q <= cnt_d;
    end

endmodule

// File: tb/tb_rle_stream_scheduler.sv
// Scoreboard bench for rle_stream_scheduler: randomized token/row traffic,
// expected bytes predicted from the framing rules, checked by a monitor.
module tb_rle_stream_scheduler;

    logic        CLK = 1'b0;
    logic        RST;
    logic [2:0]  i_tok_valid;
    logic [23:0] i_tok_val;
    logic [17:0] i_tok_count;
    logic [2:0]  o_tok_ready;
    logic        i_row_end;
    logic [7:0]  o_frame;
    logic        o_valid;
    logic        i_tx_ready;
    logic        o_row_done;

    always #5 CLK = ~CLK;

    rle_stream_scheduler #(.CountWidth(6), .RowIdxWidth(8)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .i_tok_valid (i_tok_valid),
        .i_tok_val   (i_tok_val),
        .i_tok_count (i_tok_count),
        .o_tok_ready (o_tok_ready),
        .i_row_end   (i_row_end),
        .o_frame     (o_frame),
        .o_valid     (o_valid),
        .i_tx_ready  (i_tx_ready),
        .o_row_done  (o_row_done)
    );

    typedef struct {
        logic [7:0] b;
        bit         last;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         failures = 0;
    bit [2:0]   pend_v = 3'b000;
    logic [7:0] pend_val[3];
    logic [5:0] pend_cnt[3];
    int         rowend_cnt = 0;
    bit         row_pend_m = 0;
    int         ptr_m = 0;
    logic [7:0] row_idx_m = 8'h00;
    logic [7:0] crc_m = 8'h00;
    bit         rd_exp = 0;
    bit         prev_hold = 0;
    logic [7:0] prev_frame = 8'h00;
    int         rdy_pct = 100;

    function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int i = 0; i < 8; i++) begin
            r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push_byte(input logic [7:0] b, input bit last);
        exp_t e;
        e.b = b;
        e.last = last;
        exp_q.push_back(e);
    endtask

    task automatic push_token(input int ch);
        logic [7:0] hdr;
        hdr = {2'(ch), pend_cnt[ch]};
        push_byte(hdr, 1'b0);
        push_byte(pend_val[ch], 1'b0);
        crc_m = crc8(crc8(crc_m, hdr), pend_val[ch]);
    endtask

    task automatic push_marker();
        push_byte(8'hC0, 1'b0);
`ifdef RLE_SCHED_ROW_CRC_EN
        push_byte(row_idx_m, 1'b0);
        push_byte(crc_m, 1'b1);
`else
        push_byte(row_idx_m, 1'b1);
`endif
        crc_m = 8'h00;
        row_idx_m = row_idx_m + 8'd1;
    endtask

    // Monitor: samples 1 time unit before each rising edge.
    always begin
        @(negedge CLK);
        #4;
        if (RST === 1'b1) begin
            chk("row_done", {31'd0, o_row_done}, {31'd0, rd_exp});
            if (rd_exp) begin
                row_pend_m = 0;
            end
            rd_exp = 0;
            if (prev_hold) begin
                chk("hold_valid", {31'd0, o_valid}, 32'd1);
                chk("hold_frame", {24'd0, o_frame}, {24'd0, prev_frame});
            end
            if (o_tok_ready != 3'b000) begin
                if (pend_v == 3'b000) begin
                    chk("spurious_grant", {29'd0, o_tok_ready}, 32'd0);
                end else begin
                    int g;
                    g = -1;
                    for (int k = 0; k < 3; k++) begin
                        if (g < 0 && pend_v[(ptr_m + k) % 3]) g = (ptr_m + k) % 3;
                    end
                    chk("grant", {29'd0, o_tok_ready}, 32'd1 << g);
                    chk("grant_tx_ready", {31'd0, i_tx_ready}, 32'd1);
                    ptr_m = (g + 1) % 3;
                    pend_v[g] = 1'b0;
                    if (pend_cnt[g] != 6'd0) push_token(g);
                    if (row_pend_m && pend_v == 3'b000) push_marker();
                end
            end
            if (o_valid && i_tx_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_byte", {24'd0, o_frame}, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("byte", {24'd0, o_frame}, {24'd0, e.b});
                    if (e.last) rd_exp = 1;
                end
            end
            prev_hold = o_valid && !i_tx_ready;
            prev_frame = o_frame;
        end
    end

    task automatic cycle();
        @(negedge CLK);
        i_tok_valid = pend_v;
        i_tok_val   = {pend_val[2], pend_val[1], pend_val[0]};
        i_tok_count = {pend_cnt[2], pend_cnt[1], pend_cnt[0]};
        i_row_end   = (rowend_cnt > 0);
        if (rowend_cnt > 0) rowend_cnt--;
        i_tx_ready  = ($urandom_range(99) < rdy_pct);
    endtask

    task automatic issue(input bit [2:0] mask, input logic [23:0] vals,
                         input logic [17:0] cnts, input int re);
        int n;
        n = 0;
        while ((pend_v != 3'b000 || row_pend_m) && n < 500) begin
            cycle();
            n++;
        end
        if (n >= 500) begin
            checks++;
            failures++;
            $display("FAIL issue_timeout pend=%0b row_pend=%0d required=idle", pend_v, row_pend_m);
            pend_v = 3'b000;
            row_pend_m = 0;
        end
        for (int c = 0; c < 3; c++) begin
            pend_val[c] = vals[8*c +: 8];
            pend_cnt[c] = cnts[6*c +: 6];
        end
        pend_v = mask;
        if (re > 0) begin
            row_pend_m = 1;
            rowend_cnt = re;
            if (mask == 3'b000) push_marker();
        end
        cycle();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || pend_v != 3'b000 || row_pend_m) && n < 3000) begin
            cycle();
            n++;
        end
        if (n >= 3000) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout left=%0d required=0", exp_q.size());
        end
        repeat (3) cycle();
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog time=%0t required=finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int c = 0; c < 3; c++) begin
            pend_val[c] = 8'h00;
            pend_cnt[c] = 6'd0;
        end
        RST = 1'b0;
        i_tok_valid = 3'b111;
        i_tok_val = 24'hFFFFFF;
        i_tok_count = 18'h3FFFF;
        i_row_end = 1'b0;
        i_tx_ready = 1'b1;
        repeat (3) @(negedge CLK);
        #2;
        chk("rst_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_frame", {24'd0, o_frame}, 32'd0);
        chk("rst_tok_ready", {29'd0, o_tok_ready}, 32'd0);
        chk("rst_row_done", {31'd0, o_row_done}, 32'd0);
        cycle();
        RST = 1'b1;

        // Directed: CRC example row, single Y, Y/U/V twice, row with U pending.
        issue(3'b001, 24'h000000, {6'd0, 6'd0, 6'd1}, 1);
        issue(3'b001, 24'h000080, {6'd0, 6'd0, 6'd5}, 0);
        issue(3'b111, 24'h302010, {6'd3, 6'd2, 6'd1}, 0);
        issue(3'b111, 24'h302010, {6'd3, 6'd2, 6'd1}, 0);
        issue(3'b010, 24'h00AB00, {6'd0, 6'd9, 6'd0}, 1);
        issue(3'b000, 24'h000000, 18'd0, 2);
        issue(3'b011, 24'h00CD11, {6'd0, 6'd4, 6'd0}, 0);
        drain();

        rdy_pct = 60;
        for (int t = 0; t < 300; t++) begin
            bit [2:0] m;
            logic [17:0] cn;
            int re;
            m = 3'($urandom_range(7));
            re = ($urandom_range(3) == 0) ? $urandom_range(1, 2) : 0;
            for (int c = 0; c < 3; c++) begin
                cn[6*c +: 6] = ($urandom_range(7) == 0) ? 6'd0 : 6'($urandom_range(63));
            end
            if (m != 3'b000 || re != 0) issue(m, 24'($urandom), cn, re);
        end
        drain();

        rdy_pct = 80;
        for (int r = 0; r < 258; r++) begin
            issue(3'b000, 24'h0, 18'd0, 1);
        end
        drain();

        // Reset while the value byte is stalled on the UART.
        rdy_pct = 100;
        issue(3'b001, 24'h00005A, {6'd0, 6'd0, 6'd7}, 0);
        for (int n = 0; n < 20 && exp_q.size() != 1; n++) cycle();
        rdy_pct = 0;
        i_tx_ready = 1'b0;
        i_tok_valid = 3'b111;
        #1;
        RST = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, o_valid}, 32'd0);
        chk("midrst_frame", {24'd0, o_frame}, 32'd0);
        chk("midrst_tok_ready", {29'd0, o_tok_ready}, 32'd0);
        exp_q.delete();
        pend_v = 3'b000;
        ptr_m = 0;
        row_idx_m = 8'h00;
        crc_m = 8'h00;
        row_pend_m = 0;
        rd_exp = 0;
        prev_hold = 0;
        rowend_cnt = 0;
        repeat (2) cycle();
        RST = 1'b1;
        rdy_pct = 70;
        issue(3'b111, 24'h302010, {6'd3, 6'd2, 6'd1}, 1);
        issue(3'b000, 24'h0, 18'd0, 1);
        drain();
        chk("queue_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rle_stream_scheduler.md
# rle_stream_scheduler

Arbitrates the three per-channel RLE token streams (Y, U, V) of the row compressor and serializes them into the single byte stream that feeds the UART transmitter. Round-robin shares the one UART byte lane between the channels and frames each compressed row with an end-of-row marker. Sits between the RLE stages and the UART TX.

## Interface
- `CountWidth`, 6: run-length field width; fixed at 6 so tag + count fill one byte.
- `RowIdxWidth`, 8: row index counter width, emitted as one byte.
- `CLK` in 1: clock.
- `RST` in 1: reset, asynchronous, active-low.
- `i_tok_valid` in 3: token valid per channel, bit0 Y, bit1 U, bit2 V.
- `i_tok_val` in 24: token values, {V,U,Y}, 8 bits each.
- `i_tok_count` in 18: run lengths, {V,U,Y}, 6 bits each.
- `o_tok_ready` out 3: one-hot token accept.
- `i_row_end` in 1: single-cycle pulse, row fully pushed into the RLE stages.
- `o_frame` out 8: byte to UART.
- `o_valid` out 1: `o_frame` valid.
- `i_tx_ready` in 1: UART accepts byte.
- `o_row_done` out 1: one-cycle pulse after last framing byte accepted.

## Operation
- Token encoding, 2 bytes: header {tag[1:0], count[5:0]}, tag Y=00 U=01 V=10; then value byte.
- Tag 11 reserved for control: marker byte 0xC0, then row index byte.
- States: ARB, HDR, VAL, MARK, ROWIDX, CRC (CRC only with macro).
- ARB: if any `i_tok_valid`, grant round-robin from pointer; `o_tok_ready[grant]`=1 combinationally this cycle only, capture val/count, go HDR. Pointer moves to grant+1 (V wraps to Y).
- Count 0: token consumed, no bytes emitted, stay ARB.
- HDR -> VAL -> ARB, each advancing on `o_valid & i_tx_ready`.
- `i_row_end` sets sticky `row_pend`. In ARB with `row_pend` and no `i_tok_valid`: go MARK -> ROWIDX -> ARB (or CRC -> ARB). On leaving: clear `row_pend`, row index +1 (255 wraps to 0), pulse `o_row_done`.
- Pending tokens always precede the marker; `i_row_end` arriving while `row_pend` set is absorbed (no double marker).
- `o_frame`/`o_valid` held stable until accepted; never retracted.

## Timing
- Reset values: `o_frame`=0, `o_valid`=0, `o_tok_ready`=0 (forced while `RST` low), `o_row_done`=0; state ARB, pointer Y, row index 0, `row_pend`=0, CRC 0.
- Token accepted cycle N -> header byte valid N+1; value byte earliest N+2; next grant earliest N+3 (zero stall).
- Marker valid 1 cycle after qualifying ARB cycle.
- Reset mid-operation: immediate async clear; partially sent token and pending row end discarded.
- `i_tx_ready` low: all state frozen, no new grants.

## Configuration
- `RLE_SCHED_ROW_CRC_EN` defined: CRC-8 (poly 0x07, init 0x00, MSB-first) over every header and value byte of the row; sent as third framing byte after row index; CRC cleared after it is accepted.
- Undefined: no CRC state, framing is 0xC0 + row index only.

## Structure
- Shared package: tag constants (Y/U/V/CTRL), marker byte 0xC0, CRC poly/init, state encoding.
- One sub-module natural: `rle_crc8_byte`, combinational next-CRC from (crc, byte), instantiated only under the macro.

## Test plan
- Single Y token count 5 val 0x80, `i_tx_ready`=1 -> bytes 0x05, 0x80; `o_tok_ready`=001 for one cycle.
- Y, U, V valid together, counts 1/2/3, vals 0x10/0x20/0x30 -> 0x01 0x10, 0x42 0x20, 0x83 0x30 in that order; repeat -> order continues from Y.
- `i_row_end` with U token pending, row index 0 -> U token bytes, then 0xC0 0x00, `o_row_done` pulse; next row's marker 0xC0 0x01; after 256 rows index wraps to 0x00.
- `i_tx_ready` toggled randomly -> `o_frame` stable while `o_valid & !i_tx_ready`; no token lost or duplicated.
- Count-0 token -> consumed, no bytes; `RST` low mid-value-byte -> `o_valid` 0 immediately, restart at ARB with pointer Y.
- With `RLE_SCHED_ROW_CRC_EN`: row Y count 1 val 0x00 -> 0x01 0x00 0xC0 0x00 then CRC-8 of {0x01,0x00} = 0x15.
